irq_vector_ctrl: RTL and testbench
==================================

# irq_vector_ctrl

Parametrised interrupt controller for the CPU's interrupt path. It latches edge-triggered requests on `N_CH` channels, applies per-channel and global masks, and selects the highest-priority eligible channel. It presents that channel's service-routine address to the control unit through a request/acknowledge handshake and tracks nested in-service levels until the matching return.

## Interface
Parameters:
- `N_CH`, default 4: number of interrupt channels, 2..32.
- `ADDR_W`, default 32: width of the vector address.
- `VEC_BASE`, default 32'h00DB: vector address of channel 0.
- `VEC_STRIDE`, default 32'h0034: address spacing between consecutive channels.
- `CW`, derived as clog2(`N_CH`): width of the channel code.

Ports:
- `in_clk`, input, 1: single clock, rising edge.
- `in_rst`, input, 1: reset, asynchronous and active-high.
- `in_irq`, input, `N_CH`: raw request lines, one per channel.
- `in_mask`, input, `N_CH`: per-channel enable, 1 = enabled.
- `in_ie`, input, 1: global interrupt enable from the CPU.
- `in_ack`, input, 1: CPU accepts the presented vector; one-cycle pulse.
- `in_eret`, input, 1: CPU returns from the current service routine; one-cycle pulse.
- `out_req`, output, 1: interrupt request to the CPU.
- `out_code`, output, `CW`: channel number being requested.
- `out_addr`, output, `ADDR_W`: service-routine address for `out_code`.
- `out_pending`, output, `N_CH`: latched pending bits.
- `out_inservice`, output, `N_CH`: channels currently in service.

## Operation
- **Reset.** `in_rst`=1 asynchronously clears all state: `out_req`=0, `out_code`=0, `out_addr`=0, `out_pending`=0, `out_inservice`=0, the `in_irq` history register, and the FSM (state IDLE).
- **Edge detect.** `pending[i]` is set on the first clock where `in_irq[i]`=1 and the previous sample was 0. Because the history register resets to 0, a line held high through reset registers as one edge.
- **Priority.** A lower channel index has higher priority.
- **Current level.** The current level is the lowest index set in `out_inservice`. If no bit is set, the level is `N_CH`.
- **Eligibility.** Channel i is eligible when `pending[i]` & `in_mask[i]` & `in_ie` & (i < current level). Only a strictly higher-priority channel may preempt. The candidate is the lowest eligible index.
- **Vector arithmetic.** `out_addr` = `VEC_BASE` + `out_code`*`VEC_STRIDE`, truncated to `ADDR_W` bits. With the default parameters the vectors are 0x00DB, 0x010F, 0x0143 and 0x0177.
- **FSM states:**
  - IDLE: `out_req`=0. If a candidate exists, register its code and address and move to REQ.
  - REQ: `out_req`=1. `out_code` and `out_addr` are frozen, even if a higher-priority channel becomes pending.
    - If the frozen channel is no longer eligible (`in_ie`=0 or `in_mask` bit cleared), withdraw: go to IDLE with `out_req`=0. The pending bit is kept.
    - On `in_ack`: clear `pending[code]`, set `inservice[code]`, and go to ACKD.
  - ACKD: `out_req`=0 for one cycle, then IDLE.
- **Ignored inputs.** `in_ack` outside REQ has no effect. `in_eret` with `out_inservice`=0 has no effect.
- **Return.** `in_eret` clears the lowest set bit of `out_inservice`. It may occur in any state.
- **Simultaneous events:**
  - New edge on channel i in the same cycle as the ack that clears `pending[i]`: set wins, so `pending[i]` stays 1.
  - `in_ack` and `in_eret` in the same cycle: both apply. The eret bit is computed from the old `out_inservice`. The ack bit is always of higher priority than that bit, so the two never collide.
  - Withdrawal condition and `in_ack` in the same cycle: ack wins.
- **Reset mid-handshake.** Reset during REQ or ACKD drops `out_req` immediately (asynchronously). The request is lost and its pending bit is cleared.

## Timing
- **Request latency.** With `in_irq[i]` first sampled high at edge k:
  - `pending[i]`=1 after edge k.
  - FSM enters REQ at edge k+1; `out_req`, `out_code` and `out_addr` are valid after edge k+1.
  - Minimum latency is 2 cycles.
- **Acknowledge.** With `in_ack` sampled at edge m:
  - `out_req`=0, `pending` cleared and `inservice` set after edge m.
  - IDLE at edge m+1.
  - The earliest next `out_req` is after edge m+2.
- **Return.** `in_eret` at edge n: `out_inservice` is updated after edge n. A newly unblocked request can be in REQ after edge n+1.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset and single request.** Reset with `in_irq`=0, then release. Pulse `in_irq[2]` with `in_mask`=4'hF and `in_ie`=1. Required: `out_req` rises 2 cycles later with `out_code`=2 and `out_addr`=0x0143. Ack → `out_inservice`=4'b0100 and `out_pending`=0.
- **Priority.** Raise channels 1 and 3 in the same cycle. Required: first vector 0x010F. After ack and eret, the second vector is 0x0177 with `out_code`=3.
- **Nesting.** Channel 2 is in service. Raising channel 3 gives no `out_req`. Raising channel 0 gives `out_req` with 0x00DB; ack → `out_inservice`=4'b0101. First eret → 4'b0100; the pending channel 3 stays blocked. Second eret → 4'b0000, then channel 3 is requested.
- **Withdrawal.** While in REQ for channel 1, drop `in_ie`. Required: `out_req`=0 next cycle and `out_pending[1]` still 1. Restoring `in_ie` re-requests 0x010F.
- **Frozen vector and edge/ack collision.** In REQ for channel 2, raise channel 0. Required: `out_addr` stays 0x0143 until ack; channel 0 is then requested after ACKD and IDLE. Also apply a new edge on channel 2 in its ack cycle: `out_pending[2]` must stay 1.
- **Parameter sweep.** `N_CH`=8, `VEC_BASE`=32'h1000, `VEC_STRIDE`=32'h40. Request channel 7. Required: `out_code`=3'd7 and `out_addr`=0x11C0. Assert reset mid-REQ: all outputs go to 0 immediately.

Source files
------------

// File: rtl/irq_vector_ctrl.sv
// rtl/irq_vector_ctrl.sv - edge-latched, masked, nesting interrupt vector controller
module irq_vector_ctrl #(
   parameter int N_CH = 4,
   parameter int ADDR_W = 32,
   parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(32'h00DB),
   parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(32'h0034),
   localparam int CW = $clog2(N_CH)
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic [N_CH-1:0]   in_irq,
   input  logic [N_CH-1:0]   in_mask,
   input  logic              in_ie,
   input  logic              in_ack,
   input  logic              in_eret,
   output logic              out_req,
   output logic [CW-1:0]     out_code,
   output logic [ADDR_W-1:0] out_addr,
   output logic [N_CH-1:0]   out_pending,
   output logic [N_CH-1:0]   out_inservice
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_ACKD = 2'd2;

   logic [1:0]        state;
   logic [N_CH-1:0]   irq_q;
   logic [N_CH-1:0]   pending;
   logic [N_CH-1:0]   inservice;
   logic [N_CH-1:0]   rise;
   logic [N_CH-1:0]   below_level;
   logic [N_CH-1:0]   eligible;
   logic [N_CH-1:0]   ack_set;
   logic [N_CH-1:0]   eret_clr;
   logic              cand_valid;
   logic [CW-1:0]     cand_code;
   logic [ADDR_W-1:0] cand_addr;
   logic              frozen_ok;
   logic              ack_fire;
   logic              seen;

   assign rise = in_irq & ~irq_q;

   // Channels strictly above the current in-service level (below_level[i] means i < level)
   always_comb begin
      seen = 1'b0;
      below_level = '0;
      for (int i = 0; i < N_CH; i++) begin
         seen = seen | inservice[i];
         below_level[i] = ~seen;
      end
   end

   assign eligible = pending & in_mask & {N_CH{in_ie}} & below_level;

   // Lowest eligible index wins
   always_comb begin
      cand_valid = 1'b0;
      cand_code = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            cand_valid = 1'b1;
            cand_code = CW'(i);
         end
      end
   end

   assign cand_addr = VEC_BASE + ADDR_W'(cand_code) * VEC_STRIDE;
   assign frozen_ok = in_ie & in_mask[code_idx()];
   assign ack_fire  = (state == ST_REQ) & in_ack;
   assign ack_set   = ack_fire ? (N_CH'(1) << out_code) : '0;
   // Lowest set in-service bit is the routine being returned from
   assign eret_clr  = in_eret ? (inservice & (~inservice + N_CH'(1))) : '0;

   function automatic logic [CW-1:0] code_idx();
      return out_code;
   endfunction

   // Request history, pending latch and in-service tracking
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         irq_q     <= '0;
         pending   <= '0;
         inservice <= '0;
      end else begin
         irq_q     <= in_irq;
         pending   <= (pending & ~ack_set) | rise;
         inservice <= (inservice & ~eret_clr) | ack_set;
      end
   end

   // Request/acknowledge handshake; vector is frozen while requesting
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state    <= ST_IDLE;
         out_req  <= 1'b0;
         out_code <= '0;
         out_addr <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cand_valid) begin
                  state    <= ST_REQ;
                  out_req  <= 1'b1;
                  out_code <= cand_code;
                  out_addr <= cand_addr;
               end
            end
            ST_REQ: begin
               if (in_ack) begin
                  state   <= ST_ACKD;
                  out_req <= 1'b0;
               end else if (!frozen_ok) begin
                  state   <= ST_IDLE;
                  out_req <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               out_req <= 1'b0;
            end
         endcase
      end
   end

   assign out_pending   = pending;
   assign out_inservice = inservice;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// tb/tb_irq_vector_ctrl.sv - directed self-checking bench for irq_vector_ctrl
module tb_irq_vector_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  irq;
   logic [3:0]  mask;
   logic        ie;
   logic        ack;
   logic        eret;
   logic        req;
   logic [1:0]  code;
   logic [31:0] addr;
   logic [3:0]  pend;
   logic [3:0]  insv;

   logic        rst8;
   logic [7:0]  irq8;
   logic [7:0]  mask8;
   logic        ie8;
   logic        ack8;
   logic        eret8;
   logic        req8;
   logic [2:0]  code8;
   logic [31:0] addr8;
   logic [7:0]  pend8;
   logic [7:0]  insv8;

   int checks = 0;
   int errors = 0;

   irq_vector_ctrl dut (
      .in_clk(clk), .in_rst(rst), .in_irq(irq), .in_mask(mask), .in_ie(ie),
      .in_ack(ack), .in_eret(eret), .out_req(req), .out_code(code),
      .out_addr(addr), .out_pending(pend), .out_inservice(insv)
   );

   irq_vector_ctrl #(.N_CH(8), .ADDR_W(32), .VEC_BASE(32'h1000), .VEC_STRIDE(32'h40)) dut8 (
      .in_clk(clk), .in_rst(rst8), .in_irq(irq8), .in_mask(mask8), .in_ie(ie8),
      .in_ack(ack8), .in_eret(eret8), .out_req(req8), .out_code(code8),
      .out_addr(addr8), .out_pending(pend8), .out_inservice(insv8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; irq = 4'h0; mask = 4'hF; ie = 1; ack = 0; eret = 0;
      rst8 = 1; irq8 = 8'h00; mask8 = 8'hFF; ie8 = 1; ack8 = 0; eret8 = 0;
      tick(); tick();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", req); end
      checks++; if (code !== 2'd0) begin errors++; $display("FAIL reset_code got %0d want 0", code); end
      checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", addr); end
      checks++; if (pend !== 4'h0) begin errors++; $display("FAIL reset_pending got %b want 0000", pend); end
      checks++; if (insv !== 4'h0) begin errors++; $display("FAIL reset_inservice got %b want 0000", insv); end
      rst = 0; rst8 = 0;
      tick();
   endtask

   task automatic test_single();
      irq = 4'b0100; tick(); irq = 4'b0000;
      checks++; if (pend !== 4'b0100) begin errors++; $display("FAIL single_pending got %b want 0100", pend); end
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_req_early got %b want 0", req); end
      tick();
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL single_req got %b want 1", req); end
      checks++; if (code !== 2'd2) begin errors++; $display("FAIL single_code got %0d want 2", code); end
      checks++; if (addr !== 32'h0143) begin errors++; $display("FAIL single_addr got %h want 00000143", addr); end
      ack = 1; tick(); ack = 0;
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_ack_req got %b want 0", req); end
      checks++; if (insv !== 4'b0100) begin errors++; $display("FAIL single_inservice got %b want 0100", insv); end
      checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL single_pend_clr got %b want 0000", pend); end
      tick();
   endtask

   task automatic test_nesting();
      irq = 4'b1000; tick(); irq = 4'b0000;
      tick(); tick();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL nest_blocked got %b want 0", req); end
      irq = 4'b0001; tick(); irq = 4'b0000; tick();
      checks++; if (req !== 1'b1 || addr !== 32'h00DB) begin errors++; $display("FAIL nest_preempt got req %b addr %h want 1 000000db", req, addr); end
      ack = 1; tick(); ack = 0;
      checks++; if (insv !== 4'b0101) begin errors++; $display("FAIL nest_inservice got %b want 0101", insv); end
      tick(); tick();
      eret = 1; tick(); eret = 0;
      checks++; if (insv !== 4'b0100) begin errors++; $display("FAIL nest_eret1 got %b want 0100", insv); end
      tick(); tick();
      checks++; if (req !== 1'b0 || pend !== 4'b1000) begin errors++; $display("FAIL nest_still_blocked got req %b pend %b want 0 1000", req, pend); end
      eret = 1; tick(); eret = 0;
      checks++; if (insv !== 4'b0000) begin errors++; $display("FAIL nest_eret2 got %b want 0000", insv); end
      tick();
      checks++; if (req !== 1'b1 || code !== 2'd3 || addr !== 32'h0177) begin errors++; $display("FAIL nest_ch3 got req %b code %0d addr %h want 1 3 00000177", req, code, addr); end
      ack = 1; tick(); ack = 0;
      eret = 1; tick(); eret = 0;
      checks++; if (insv !== 4'b0000) begin errors++; $display("FAIL nest_cleanup got %b want 0000", insv); end
   endtask

   task automatic test_priority();
      irq = 4'b1010; tick(); irq = 4'b0000; tick();
      checks++; if (req !== 1'b1 || code !== 2'd1 || addr !== 32'h010F) begin errors++; $display("FAIL prio_first got req %b code %0d addr %h want 1 1 0000010f", req, code, addr); end
      ack = 1; tick(); ack = 0;
      tick(); tick();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL prio_blocked got %b want 0", req); end
      eret = 1; tick(); eret = 0; tick();
      checks++; if (req !== 1'b1 || code !== 2'd3 || addr !== 32'h0177) begin errors++; $display("FAIL prio_second got req %b code %0d addr %h want 1 3 00000177", req, code, addr); end
      ack = 1; tick(); ack = 0;
      eret = 1; tick(); eret = 0;
   endtask

   task automatic test_withdraw();
      irq = 4'b0010; tick(); irq = 4'b0000; tick();
      checks++; if (req !== 1'b1 || code !== 2'd1) begin errors++; $display("FAIL wd_req got req %b code %0d want 1 1", req, code); end
      ie = 0; tick();
      checks++; if (req !== 1'b0 || pend[1] !== 1'b1) begin errors++; $display("FAIL wd_drop got req %b pend %b want 0 x x1x", req, pend); end
      tick();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL wd_hold got %b want 0", req); end
      ie = 1; tick();
      checks++; if (req !== 1'b1 || addr !== 32'h010F) begin errors++; $display("FAIL wd_rereq got req %b addr %h want 1 0000010f", req, addr); end
      ack = 1; tick(); ack = 0;
      eret = 1; tick(); eret = 0;
      checks++; if (insv !== 4'b0000 || pend !== 4'b0000) begin errors++; $display("FAIL wd_cleanup got insv %b pend %b want 0000 0000", insv, pend); end
   endtask

   task automatic test_frozen();
      irq = 4'b0100; tick(); irq = 4'b0000; tick();
      irq = 4'b0001; tick(); irq = 4'b0000;
      checks++; if (req !== 1'b1 || code !== 2'd2 || addr !== 32'h0143) begin errors++; $display("FAIL frz_hold got req %b code %0d addr %h want 1 2 00000143", req, code, addr); end
      tick();
      checks++; if (addr !== 32'h0143) begin errors++; $display("FAIL frz_hold2 got %h want 00000143", addr); end
      irq = 4'b0100; ack = 1; tick(); irq = 4'b0000; ack = 0;
      checks++; if (pend !== 4'b0101) begin errors++; $display("FAIL frz_edge_ack got %b want 0101", pend); end
      checks++; if (req !== 1'b0 || insv !== 4'b0100) begin errors++; $display("FAIL frz_ackd got req %b insv %b want 0 0100", req, insv); end
      tick();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL frz_idle got %b want 0", req); end
      tick();
      checks++; if (req !== 1'b1 || code !== 2'd0 || addr !== 32'h00DB) begin errors++; $display("FAIL frz_ch0 got req %b code %0d addr %h want 1 0 000000db", req, code, addr); end
   endtask

   task automatic test_param();
      irq8 = 8'h80; tick(); irq8 = 8'h00;
      checks++; if (pend8 !== 8'h80 || req8 !== 1'b0) begin errors++; $display("FAIL p8_pending got pend %h req %b want 80 0", pend8, req8); end
      tick();
      checks++; if (req8 !== 1'b1 || code8 !== 3'd7 || addr8 !== 32'h11C0) begin errors++; $display("FAIL p8_req got req %b code %0d addr %h want 1 7 000011c0", req8, code8, addr8); end
      rst8 = 1; #1;
      checks++; if (req8 !== 1'b0 || code8 !== 3'd0 || addr8 !== 32'h0 || pend8 !== 8'h0 || insv8 !== 8'h0) begin
         errors++; $display("FAIL p8_async_rst got req %b code %0d addr %h pend %h insv %h want all 0", req8, code8, addr8, pend8, insv8);
      end
      tick(); rst8 = 0; tick();
      checks++; if (req8 !== 1'b0 || pend8 !== 8'h0) begin errors++; $display("FAIL p8_after_rst got req %b pend %h want 0 00", req8, pend8); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_nesting();
      test_priority();
      test_withdraw();
      test_frozen();
      test_param();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
